dual_issue_ctrl: RTL

- Issue stage for the dual-lane datapath; the producer end of the two-lane execute interface.
- Accepts a decoded instruction pair (slots A, B) per cycle and checks intra-pair register hazards.
- Issues both instructions together, or splits the pair over two cycles, into registered lane-A/lane-B outputs.
- Provides valid/ready flow control toward decode and execute, plus a flush.

---
 rtl/issue_pkg.sv | 26 ++
 rtl/pair_hazard_check.sv | 27 ++
 rtl/dual_issue_ctrl.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/issue_pkg.sv
// Shared types for the dual-lane issue stage: FSM state, the x0 register
// specifier, and the packed per-slot payload used by the hold and lane registers.
package issue_pkg;

    localparam int DATA_W    = 32;
    localparam int REG_W     = 5;
    localparam int CTRL_BITS = 5;

    localparam logic [REG_W-1:0] REG_X0 = '0;

    typedef enum logic {
        PAIR  = 1'b0,
        SPLIT = 1'b1
    } issue_state_t;

    typedef struct packed {
        logic [REG_W-1:0]     rd;
        logic [REG_W-1:0]     rs1;
        logic [REG_W-1:0]     rs2;
        logic                 reg_write;
        logic                 use_rs2;
        logic [CTRL_BITS-1:0] ctrl;
        logic [DATA_W-1:0]    imm;
    } slot_t;

endpackage

// File: rtl/pair_hazard_check.sv
// Intra-pair hazard detection between slot A (older) and slot B (younger).
// Purely combinational; a write to x0 never creates a hazard.
module pair_hazard_check
    import issue_pkg::*;
(
    input  slot_t slot_a,
    input  slot_t slot_b,
    input  logic  slotB_valid,
    output logic  raw,
    output logic  waw,
    output logic  split
);

    logic a_writes;

    assign a_writes = slot_a.reg_write && (slot_a.rd != REG_X0);

    assign raw = slotB_valid && a_writes &&
                 ((slot_b.rs1 == slot_a.rd) ||
                  (slot_b.use_rs2 && (slot_b.rs2 == slot_a.rd)));

    assign waw = slotB_valid && a_writes && slot_b.reg_write &&
                 (slot_b.rd == slot_a.rd);

    assign split = raw || waw;

endmodule

// File: rtl/dual_issue_ctrl.sv
// Dual-lane issue stage. Takes a decoded pair per cycle, issues both slots
// together or splits them over two cycles when slot B depends on slot A,
// and drives registered lane-A/lane-B outputs toward execute.
// Optional build macro ISSUE_STATS_EN adds saturating dual/split issue counters.
module dual_issue_ctrl
    import issue_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_W,
    parameter int REG_ADDR_W = REG_W,
    parameter int CTRL_W     = CTRL_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic                  slotB_valid_i,
    input  logic [REG_ADDR_W-1:0] rdA_i,
    input  logic [REG_ADDR_W-1:0] rs1A_i,
    input  logic [REG_ADDR_W-1:0] rs2A_i,
    input  logic [REG_ADDR_W-1:0] rdB_i,
    input  logic [REG_ADDR_W-1:0] rs1B_i,
    input  logic [REG_ADDR_W-1:0] rs2B_i,
    input  logic                  regWriteA_i,
    input  logic                  regWriteB_i,
    input  logic                  useRs2A_i,
    input  logic                  useRs2B_i,
    input  logic [CTRL_W-1:0]     ctrlA_i,
    input  logic [CTRL_W-1:0]     ctrlB_i,
    input  logic [DATA_WIDTH-1:0] immA_i,
    input  logic [DATA_WIDTH-1:0] immB_i,
    input  logic                  ex_ready_i,
    output logic                  issA_valid_o,
    output logic                  issB_valid_o,
    output logic [CTRL_W-1:0]     issA_ctrl_o,
    output logic [CTRL_W-1:0]     issB_ctrl_o,
    output logic [DATA_WIDTH-1:0] issA_imm_o,
    output logic [DATA_WIDTH-1:0] issB_imm_o,
    output logic [REG_ADDR_W-1:0] issA_rd_o,
    output logic [REG_ADDR_W-1:0] issA_rs1_o,
    output logic [REG_ADDR_W-1:0] issA_rs2_o,
    output logic [REG_ADDR_W-1:0] issB_rd_o,
    output logic [REG_ADDR_W-1:0] issB_rs1_o,
    output logic [REG_ADDR_W-1:0] issB_rs2_o,
    output logic                  issA_regWrite_o,
    output logic                  issB_regWrite_o
`ifdef ISSUE_STATS_EN
   ,output logic [31:0]           statDual_o,
    output logic [31:0]           statSplit_o
`endif
);

    issue_state_t state_q;
    slot_t        hold_q;
    slot_t        lane_a_q;
    slot_t        lane_b_q;
    logic         a_valid_q;
    logic         b_valid_q;

    slot_t        slot_a;
    slot_t        slot_b;
    logic         hz_raw;
    logic         hz_waw;
    logic         hz_split;
    logic         hz_unused;
    logic         pair_fire;

    assign slot_a = '{rd: rdA_i, rs1: rs1A_i, rs2: rs2A_i, reg_write: regWriteA_i,
                      use_rs2: useRs2A_i, ctrl: ctrlA_i, imm: immA_i};
    assign slot_b = '{rd: rdB_i, rs1: rs1B_i, rs2: rs2B_i, reg_write: regWriteB_i,
                      use_rs2: useRs2B_i, ctrl: ctrlB_i, imm: immB_i};

    pair_hazard_check u_hazard (
        .slot_a      (slot_a),
        .slot_b      (slot_b),
        .slotB_valid (slotB_valid_i),
        .raw         (hz_raw),
        .waw         (hz_waw),
        .split       (hz_split)
    );

    // Individual hazard kinds are only needed for debug visibility.
    assign hz_unused = hz_raw ^ hz_waw;

    // A pair is taken only in PAIR state with execute ready and no flush or reset.
    assign in_ready_o = !rst && (state_q == PAIR) && ex_ready_i && !flush_i;
    assign pair_fire  = in_valid_i && in_ready_o;

    // Issue FSM and lane/hold registers; everything holds while execute stalls.
    // NOTE: non-blocking assignments so every register samples pre-edge values;
    // the hold register is plain flops and is cleared explicitly on reset/flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= PAIR;
            hold_q    <= '0;
            lane_a_q  <= '0;
            lane_b_q  <= '0;
            a_valid_q <= 1'b0;
            b_valid_q <= 1'b0;
        end else if (flush_i) begin
            state_q   <= PAIR;
            hold_q    <= '0;
            a_valid_q <= 1'b0;
            b_valid_q <= 1'b0;
        end else if (ex_ready_i) begin
            case (state_q)
                PAIR: begin
                    if (pair_fire) begin
                        lane_a_q  <= slot_a;
                        a_valid_q <= 1'b1;
                        if (hz_split) begin
                            hold_q    <= slot_b;
                            b_valid_q <= 1'b0;
                            state_q   <= SPLIT;
                        end else begin
                            // Invalid lane keeps its old payload so it stays deterministic.
                            if (slotB_valid_i) begin
                                lane_b_q <= slot_b;
                            end
                            b_valid_q <= slotB_valid_i;
                        end
                    end else begin
                        a_valid_q <= 1'b0;
                        b_valid_q <= 1'b0;
                    end
                end
                SPLIT: begin
                    lane_b_q  <= hold_q;
                    b_valid_q <= 1'b1;
                    a_valid_q <= 1'b0;
                    hold_q    <= '0;
                    state_q   <= PAIR;
                end
            endcase
        end
    end

    assign issA_valid_o    = a_valid_q;
    assign issB_valid_o    = b_valid_q;
    assign issA_ctrl_o     = lane_a_q.ctrl;
    assign issB_ctrl_o     = lane_b_q.ctrl;
    assign issA_imm_o      = lane_a_q.imm;
    assign issB_imm_o      = lane_b_q.imm;
    assign issA_rd_o       = lane_a_q.rd;
    assign issA_rs1_o      = lane_a_q.rs1;
    assign issA_rs2_o      = lane_a_q.rs2;
    assign issB_rd_o       = lane_b_q.rd;
    assign issB_rs1_o      = lane_b_q.rs1;
    assign issB_rs2_o      = lane_b_q.rs2;
    assign issA_regWrite_o = lane_a_q.reg_write;
    assign issB_regWrite_o = lane_b_q.reg_write;

`ifdef ISSUE_STATS_EN
    logic [31:0] dual_cnt_q;
    logic [31:0] split_cnt_q;

    // Saturating issue statistics; only reset clears them, flush does not.
    always_ff @(posedge clk) begin
        if (rst) begin
            dual_cnt_q  <= '0;
            split_cnt_q <= '0;
        end else begin
            if (pair_fire && slotB_valid_i && !hz_split && (dual_cnt_q != 32'hFFFF_FFFF)) begin
                dual_cnt_q <= dual_cnt_q + 32'd1;
            end
            if (pair_fire && hz_split && (split_cnt_q != 32'hFFFF_FFFF)) begin
                split_cnt_q <= split_cnt_q + 32'd1;
            end
        end
    end

    assign statDual_o  = dual_cnt_q;
    assign statSplit_o = split_cnt_q;
`endif

endmodule
